// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling, 2-of-3 majority voting per bit,
// optional parity, stop-bit checking and a valid/ready word output.
module uart_rx_os16 #(
    parameter int time_frequency = 100_000_000,
    parameter int baud_rate      = 9_600,
    parameter int data_width     = 8,
    parameter int stop_width     = 2,
    parameter int parity_en      = 0,
    parameter int parity_odd     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_in,
    output logic [data_width-1:0] rx_out,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  fail,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int DIV = time_frequency / (baud_rate * 16);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic PAR_ODD = (parity_odd != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] LAST_DATA = 4'(data_width - 1);
    localparam logic [3:0] LAST_STOP = 4'(stop_width - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_calc(input logic [data_width-1:0] word);
        return ^word;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  sync1_r;
    logic                  sync2_r;
    logic                  fill1_r;
    logic                  fill2_r;
    logic                  armed_r;
    logic [PW-1:0]         presc_r;
    logic [3:0]            tc_r;
    logic [3:0]            bit_cnt_r;
    logic                  samp7_r;
    logic                  samp8_r;
    logic [data_width-1:0] shift_r;
    logic                  perr_r;
    logic                  ferr_r;
    logic [data_width-1:0] rx_out_r;
    logic                  rx_valid_r;
    logic                  fail_r;
    logic                  overrun_r;
    logic                  busy_r;

    logic s;
    logic start_edge_s;
    logic presc_wrap_s;
    logic tick_s;
    logic decide_s;
    logic bit_end_s;
    logic maj_s;
    logic frame_done_s;
    logic frame_bad_s;
    logic load_s;

    assign s            = sync2_r;
    // armed_r means the last genuine (post-reset) synchronised sample was high
    assign start_edge_s = armed_r & ~s;
    assign presc_wrap_s = (presc_r == DIV_LAST);
    assign tick_s       = (state_r != ST_IDLE) && presc_wrap_s;
    assign decide_s     = tick_s && (tc_r == 4'd9);
    assign bit_end_s    = tick_s && (tc_r == 4'd15);
    assign maj_s        = (samp7_r & samp8_r) | (samp7_r & s) | (samp8_r & s);
    assign frame_done_s = (state_r == ST_STOP) && decide_s && (bit_cnt_r == LAST_STOP);
    assign frame_bad_s  = perr_r | ferr_r | ~maj_s;
    assign load_s       = frame_done_s && !frame_bad_s && (!rx_valid_r || rx_ready);

    // Input synchroniser and post-reset arming of the start-edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            fill1_r <= 1'b0;
            fill2_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= data_in;
            sync2_r <= sync1_r;
            fill1_r <= 1'b1;
            fill2_r <= fill1_r;
            armed_r <= fill2_r & sync2_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) state_nxt_s = ST_START;
                else              state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (decide_s && maj_s) state_nxt_s = ST_IDLE;
                else if (bit_end_s)    state_nxt_s = ST_DATA;
                else                   state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_DATA))
                    state_nxt_s = (parity_en != 0) ? ST_PARITY : ST_STOP;
                else
                    state_nxt_s = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) state_nxt_s = ST_STOP;
                else           state_nxt_s = ST_PARITY;
            end
            ST_STOP: begin
                if (frame_done_s) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bit timing, sampling, shifting and per-frame error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r   <= {PW{1'b0}};
            tc_r      <= 4'd0;
            bit_cnt_r <= 4'd0;
            samp7_r   <= 1'b0;
            samp8_r   <= 1'b0;
            shift_r   <= {data_width{1'b0}};
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            presc_r <= ((state_nxt_s == ST_IDLE) || presc_wrap_s) ? {PW{1'b0}} : presc_r + PW'(1);
            if (state_nxt_s == ST_IDLE) tc_r <= 4'd0;
            else if (tick_s)            tc_r <= tc_r + 4'd1;
            else                        tc_r <= tc_r;
            if (state_nxt_s != state_r) bit_cnt_r <= 4'd0;
            else if (bit_end_s)         bit_cnt_r <= bit_cnt_r + 4'd1;
            else                        bit_cnt_r <= bit_cnt_r;
            if (tick_s && (tc_r == 4'd7)) samp7_r <= s;
            else                          samp7_r <= samp7_r;
            if (tick_s && (tc_r == 4'd8)) samp8_r <= s;
            else                          samp8_r <= samp8_r;
            if ((state_r == ST_DATA) && decide_s) shift_r <= {maj_s, shift_r[data_width-1:1]};
            else                                  shift_r <= shift_r;
            if (state_r == ST_IDLE) begin
                perr_r <= 1'b0;
                ferr_r <= 1'b0;
            end else if ((state_r == ST_PARITY) && decide_s) begin
                perr_r <= (maj_s != (parity_calc(shift_r) ^ PAR_ODD));
                ferr_r <= ferr_r;
            end else if ((state_r == ST_STOP) && decide_s && !maj_s) begin
                perr_r <= perr_r;
                ferr_r <= 1'b1;
            end else begin
                perr_r <= perr_r;
                ferr_r <= ferr_r;
            end
        end
    end

    // Output word handshake and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_out_r   <= {data_width{1'b0}};
            rx_valid_r <= 1'b0;
            fail_r     <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            fail_r    <= frame_done_s && frame_bad_s;
            overrun_r <= frame_done_s && !frame_bad_s && rx_valid_r && !rx_ready;
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                rx_out_r   <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_ready) begin
                rx_out_r   <= rx_out_r;
                rx_valid_r <= 1'b0;
            end else begin
                rx_out_r   <= rx_out_r;
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_out     = rx_out_r;
    assign rx_valid   = rx_valid_r;
    assign fail       = fail_r;
    assign rx_overrun = overrun_r;
    assign busy       = busy_r;

endmodule
